// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/write-back
// so that one ALU and one unified memory port are shared across cycles.
// Waits on MemReady in FETCH/MEMRD/MEMWR, with an optional timeout into FAULT.
module multicycle_controller #(
  parameter int ALUCTL_W    = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_EN  = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [31:0]         Instruction,
  input  logic                MemReady,
  input  logic                Zero,
  input  logic                AluLsb,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic [1:0]          PCSrc,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [1:0]          BHW,
  output logic                DataMemExtendSign,
  output logic                RegWrite,
  output logic [1:0]          RegDst,
  output logic [1:0]          RegDataSel,
  output logic                MemtoReg,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [1:0]          ALUASrc,
  output logic [2:0]          ALUBSrc,
  output logic                ExtendSign,
  output logic [3:0]          State,
  output logic [CNT_W-1:0]    Retired,
  output logic                Fault
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_ALUWB   = 4'd3,
    S_MEMADDR = 4'd4,
    S_MEMRD   = 4'd5,
    S_MEMWR   = 4'd6,
    S_MEMWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_FAULT   = 4'd10
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_SPEC2  = 6'h1C;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type functs
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;  // ROTR when IR[21]=1
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;  // ROTRV when IR[6]=1
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MOVZ = 6'h0A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // SPECIAL2 functs
  localparam logic [5:0] F2_MUL = 6'h02;
  localparam logic [5:0] F2_CLZ = 6'h20;
  localparam logic [5:0] F2_CLO = 6'h21;

  // ALU A-input: rs, shamt field, constant 16 (LUI), constant zero
  localparam logic [1:0] A_RS    = 2'd0;
  localparam logic [1:0] A_SHAMT = 2'd1;
  localparam logic [1:0] A_C16   = 2'd2;
  localparam logic [1:0] A_ZERO  = 2'd3;
  // ALU B-input: rt, extended immediate, constant zero
  localparam logic [2:0] B_RT    = 3'd0;
  localparam logic [2:0] B_IMM   = 3'd1;
  localparam logic [2:0] B_ZERO  = 3'd2;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam bit TO_ON = (TIMEOUT_EN != 0);

  state_t             state_q, state_d;
  logic [31:0]        ir_q, ir_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               fault_q, fault_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic [5:0] opcode, funct;
  logic [4:0] rt;
  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rt     = ir_q[20:16];

  logic       is_jr, is_jal, is_movz, is_load, is_store, is_branch, is_jump;
  logic       is_byte, is_rfmt;
  logic       alu_ok;
  logic [3:0] alu_ctl;
  logic [1:0] alu_a;
  logic [2:0] alu_b;
  logic       alu_ext;
  logic       mem_wait, timed_out;

  assign is_jr     = (opcode == OP_RTYPE) && (funct == F_JR);
  assign is_jal    = (opcode == OP_JAL);
  assign is_movz   = (opcode == OP_RTYPE) && (funct == F_MOVZ);
  assign is_rfmt   = (opcode == OP_RTYPE) || (opcode == OP_SPEC2);
  assign is_load   = (opcode == OP_LW) || (opcode == OP_LB) || (opcode == OP_LBU);
  assign is_store  = (opcode == OP_SW);
  assign is_byte   = (opcode == OP_LB) || (opcode == OP_LBU);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BGTZ) ||
                     ((opcode == OP_REGIMM) && (rt == 5'd0 || rt == 5'd1));
  assign is_jump   = (opcode == OP_J) || is_jal || is_jr;

  // ALU op decode for arithmetic/logic instructions; alu_ok marks a legal ALU op
  always_comb begin
    alu_ok  = 1'b0;
    alu_ctl = 4'd0;
    alu_a   = A_RS;
    alu_b   = B_RT;
    alu_ext = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL:  begin alu_ok = 1'b1; alu_ctl = 4'd10; alu_a = A_SHAMT; end
          F_SRL:  if (ir_q[21]) begin alu_ok = 1'b1; alu_ctl = 4'd13; alu_a = A_SHAMT; end
          F_SLLV: begin alu_ok = 1'b1; alu_ctl = 4'd10; end
          F_SRLV: if (ir_q[6]) begin alu_ok = 1'b1; alu_ctl = 4'd13; end
          // MOVZ passes rt through (0 + rt) so Zero reflects rt == 0
          F_MOVZ: begin alu_ok = 1'b1; alu_ctl = 4'd2; alu_a = A_ZERO; end
          F_ADD, F_ADDU: begin alu_ok = 1'b1; alu_ctl = 4'd2;  end
          F_SUB, F_SUBU: begin alu_ok = 1'b1; alu_ctl = 4'd6;  end
          F_AND:  begin alu_ok = 1'b1; alu_ctl = 4'd0;  end
          F_OR:   begin alu_ok = 1'b1; alu_ctl = 4'd1;  end
          F_XOR:  begin alu_ok = 1'b1; alu_ctl = 4'd4;  end
          F_NOR:  begin alu_ok = 1'b1; alu_ctl = 4'd3;  end
          F_SLT:  begin alu_ok = 1'b1; alu_ctl = 4'd7;  end
          F_SLTU: begin alu_ok = 1'b1; alu_ctl = 4'd14; end
          default: ;
        endcase
      end
      OP_SPEC2: begin
        case (funct)
          F2_MUL:         begin alu_ok = 1'b1; alu_ctl = 4'd9;  end
          F2_CLZ, F2_CLO: begin alu_ok = 1'b1; alu_ctl = 4'd12; end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin alu_ok = 1'b1; alu_ctl = 4'd2;  alu_b = B_IMM; alu_ext = 1'b1; end
      OP_SLTI:  begin alu_ok = 1'b1; alu_ctl = 4'd7;  alu_b = B_IMM; alu_ext = 1'b1; end
      OP_SLTIU: begin alu_ok = 1'b1; alu_ctl = 4'd14; alu_b = B_IMM; alu_ext = 1'b1; end
      OP_ANDI:  begin alu_ok = 1'b1; alu_ctl = 4'd0;  alu_b = B_IMM; end
      OP_ORI:   begin alu_ok = 1'b1; alu_ctl = 4'd1;  alu_b = B_IMM; end
      OP_XORI:  begin alu_ok = 1'b1; alu_ctl = 4'd4;  alu_b = B_IMM; end
      OP_LUI:   begin alu_ok = 1'b1; alu_ctl = 4'd10; alu_a = A_C16; alu_b = B_IMM; end
      default: ;
    endcase
  end

  assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // MemReady on the limit cycle wins over the timeout
  assign timed_out = TO_ON && mem_wait && !MemReady && (wait_q == WAIT_LIMIT);

  // Next-state and control outputs
  always_comb begin
    state_d           = state_q;
    ir_d              = ir_q;
    IRWrite           = 1'b0;
    PCWrite           = 1'b0;
    PCSrc             = 2'd0;
    IorD              = 1'b0;
    MemRead           = 1'b0;
    MemWrite          = 1'b0;
    BHW               = 2'd0;
    DataMemExtendSign = 1'b0;
    RegWrite          = 1'b0;
    RegDst            = 2'd0;
    RegDataSel        = 2'd0;
    MemtoReg          = 1'b0;
    ALUControl        = '0;
    ALUASrc           = 2'd0;
    ALUBSrc           = 3'd0;
    ExtendSign        = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        BHW     = 2'd2;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ir_d    = Instruction;
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        if (ir_q == 32'd0)               state_d = S_FETCH;
        else if (alu_ok)                 state_d = S_EXEC;
        else if (is_load || is_store)    state_d = S_MEMADDR;
        else if (is_branch)              state_d = S_BRANCH;
        else if (is_jump)                state_d = S_JUMP;
        else                             state_d = S_FAULT;
      end
      S_EXEC: begin
        ALUControl = ALUCTL_W'(alu_ctl);
        ALUASrc    = alu_a;
        ALUBSrc    = alu_b;
        ExtendSign = alu_ext;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ALUControl = ALUCTL_W'(alu_ctl);
        ALUASrc    = alu_a;
        ALUBSrc    = alu_b;
        ExtendSign = alu_ext;
        RegWrite   = 1'b1;
        RegDst     = is_rfmt ? 2'd1 : 2'd0;
        if (is_movz) begin
          RegWrite   = Zero;
          RegDataSel = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_MEMADDR: begin
        ALUControl = ALUCTL_W'(4'd2);
        ALUBSrc    = B_IMM;
        ExtendSign = 1'b1;
        state_d    = is_store ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD, S_MEMWR: begin
        ALUControl        = ALUCTL_W'(4'd2);
        ALUBSrc           = B_IMM;
        ExtendSign        = 1'b1;
        IorD              = 1'b1;
        MemRead           = (state_q == S_MEMRD);
        MemWrite          = (state_q == S_MEMWR);
        BHW               = is_byte ? 2'd0 : 2'd2;
        DataMemExtendSign = (opcode == OP_LB) || (opcode == OP_LW);
        if (MemReady)       state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        else if (timed_out) state_d = S_FAULT;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        PCSrc = 2'd1;
        if (opcode == OP_REGIMM) begin
          ALUControl = ALUCTL_W'(4'd7);
          ALUBSrc    = B_ZERO;
          PCWrite    = (rt == 5'd0) ? AluLsb : !AluLsb;
        end else if (opcode == OP_BGTZ) begin
          ALUControl = ALUCTL_W'(4'd11);
          ALUBSrc    = B_ZERO;
          PCWrite    = AluLsb;
        end else begin
          ALUControl = ALUCTL_W'(4'd6);
          PCWrite    = (opcode == OP_BEQ) ? Zero : !Zero;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = is_jr ? 2'd3 : 2'd2;
        if (is_jal) begin
          RegWrite   = 1'b1;
          RegDst     = 2'd2;
          RegDataSel = 2'd1;
        end
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // Retire count, sticky fault and memory wait counter
  always_comb begin
    retired_d = retired_q;
    if (state_q != S_FETCH && state_d == S_FETCH)
      retired_d = retired_q + CNT_W'(1);
    fault_d = fault_q | (state_d == S_FAULT);
    wait_d  = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (mem_wait && !MemReady && wait_q != WAIT_LIMIT)
      wait_d = wait_q + WAIT_W'(1);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
    end
  end

  assign State   = state_q;
  assign Retired = retired_q;
  assign Fault   = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with CNT_W=4 and MEM_TIMEOUT=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expected values are hand-computed constants for each cycle of each instruction.
module tb_multicycle_controller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Instruction;
  logic        MemReady, Zero, AluLsb;
  logic        IRWrite, PCWrite, IorD, MemRead, MemWrite;
  logic [1:0]  PCSrc, BHW, RegDst, RegDataSel;
  logic        DataMemExtendSign, RegWrite, MemtoReg, ExtendSign, Fault;
  logic [3:0]  ALUControl;
  logic [1:0]  ALUASrc;
  logic [2:0]  ALUBSrc;
  logic [3:0]  State;
  logic [3:0]  Retired;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_SW   = 32'hAC220004;
  localparam logic [31:0] I_BEQ  = 32'h10220003;
  localparam logic [31:0] I_BNE  = 32'h14220003;
  localparam logic [31:0] I_BGEZ = 32'h04210002;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_MOVZ = 32'h0022180A;
  localparam logic [31:0] I_BAD  = 32'hFC000000;

  multicycle_controller #(
    .ALUCTL_W(4), .CNT_W(4), .MEM_TIMEOUT(4), .TIMEOUT_EN(1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .MemReady(MemReady),
    .Zero(Zero), .AluLsb(AluLsb), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .BHW(BHW), .DataMemExtendSign(DataMemExtendSign), .RegWrite(RegWrite),
    .RegDst(RegDst), .RegDataSel(RegDataSel), .MemtoReg(MemtoReg),
    .ALUControl(ALUControl), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc),
    .ExtendSign(ExtendSign), .State(State), .Retired(Retired), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just past it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
  endtask

  initial begin
    Reset = 1'b0; Instruction = '0; MemReady = 1'b0; Zero = 1'b0; AluLsb = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    chk("rst_state",   State, 0);
    chk("rst_retired", Retired, 0);
    chk("rst_fault",   Fault, 0);
    chk("rst_memread", MemRead, 1);
    chk("rst_irwrite", IRWrite, 0);

    // ADD: 0 -> 1 -> 2 -> 3 -> 0
    Instruction = I_ADD; MemReady = 1'b1; #1;
    chk("add_f_irw", IRWrite, 1);
    chk("add_f_pcw", PCWrite, 1);
    tick(); chk("add_s1", State, 1);
    tick(); chk("add_s2", State, 2); chk("add_ex_alu", ALUControl, 2); chk("add_ex_rw", RegWrite, 0);
    tick(); chk("add_s3", State, 3); chk("add_wb_rw", RegWrite, 1);
    chk("add_wb_dst", RegDst, 1); chk("add_wb_alu", ALUControl, 2);
    tick(); chk("add_s0", State, 0); chk("add_ret", Retired, 1);

    // LW with three wait cycles in MEMRD: 8 cycles total
    do_reset();
    Instruction = I_LW; MemReady = 1'b1;
    tick(); chk("lw_s1", State, 1);
    tick(); chk("lw_s4", State, 4); chk("lw_addr_bsrc", ALUBSrc, 1); chk("lw_addr_ext", ExtendSign, 1);
    MemReady = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReady = 1'b1;
      #1;
      chk("lw_rd_state", State, 5);
      chk("lw_rd_memread", MemRead, 1);
      chk("lw_rd_iord", IorD, 1);
      tick();
    end
    chk("lw_rd_done", State, 7); chk("lw_wb_m2r", MemtoReg, 1); chk("lw_wb_rw", RegWrite, 1);
    tick(); chk("lw_s0", State, 0); chk("lw_ret", Retired, 1);

    // BEQ taken, BNE not taken, BGEZ taken, JAL, MOVZ
    do_reset();
    Instruction = I_BEQ; MemReady = 1'b1; Zero = 1'b1;
    tick(); Instruction = I_BNE;
    tick(); chk("beq_s8", State, 8); chk("beq_alu", ALUControl, 6);
    chk("beq_pcw", PCWrite, 1); chk("beq_pcsrc", PCSrc, 1);
    tick(); chk("beq_ret", Retired, 1);
    tick(); tick(); chk("bne_s8", State, 8); chk("bne_pcw", PCWrite, 0); chk("bne_pcsrc", PCSrc, 1);
    Instruction = I_BGEZ; AluLsb = 1'b0;
    tick(); chk("bne_ret", Retired, 2);
    tick(); tick(); chk("bgez_alu", ALUControl, 7); chk("bgez_pcw", PCWrite, 1);
    Instruction = I_JAL;
    tick(); tick(); tick();
    chk("jal_s9", State, 9); chk("jal_pcsrc", PCSrc, 2); chk("jal_pcw", PCWrite, 1);
    chk("jal_rw", RegWrite, 1); chk("jal_dst", RegDst, 2); chk("jal_dsel", RegDataSel, 1);
    Instruction = I_MOVZ;
    tick(); tick(); tick(); tick();
    Zero = 1'b1; #1;
    chk("movz_s3", State, 3); chk("movz_rw1", RegWrite, 1); chk("movz_dsel", RegDataSel, 2);
    Zero = 1'b0; #1;
    chk("movz_rw0", RegWrite, 0);
    tick(); chk("movz_ret", Retired, 5);

    // Illegal opcode: sticky fault until reset
    do_reset();
    Instruction = I_BAD; MemReady = 1'b1;
    tick(); chk("bad_s1", State, 1);
    tick(); chk("bad_s10", State, 10);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bad_fault_hold", Fault, 1);
    end
    chk("bad_state_hold", State, 10); chk("bad_ret", Retired, 0); chk("bad_rw", RegWrite, 0);
    Reset = 1'b0; tick(); Reset = 1'b1; #1;
    chk("bad_rst_state", State, 0); chk("bad_rst_fault", Fault, 0);

    // Fetch timeout: fault on the 5th edge with MemReady low
    do_reset();
    MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait", State, 0);
    end
    tick(); chk("to_state", State, 10); chk("to_fault", Fault, 1);

    // MemReady on the limit cycle wins
    do_reset();
    MemReady = 1'b0; Instruction = 32'd0;
    for (int i = 0; i < 4; i++) tick();
    MemReady = 1'b1;
    tick(); chk("to_win_state", State, 1); chk("to_win_fault", Fault, 0);

    // 16 NOPs wrap a 4-bit retire counter
    do_reset();
    Instruction = 32'd0; MemReady = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("wrap_15", Retired, 15);
    tick(); tick();
    chk("wrap_0", Retired, 0); chk("wrap_state", State, 0);

    // Reset in the middle of a store wait
    do_reset();
    Instruction = I_SW; MemReady = 1'b1;
    tick(); tick();
    MemReady = 1'b0;
    tick(); chk("sw_s6", State, 6); chk("sw_memwrite", MemWrite, 1);
    chk("sw_iord", IorD, 1); chk("sw_bhw", BHW, 2);
    Reset = 1'b0; tick(); Reset = 1'b1; #1;
    chk("sw_rst_memwrite", MemWrite, 0); chk("sw_rst_state", State, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
